// File: rtl/ma_stage_if.sv
// Data-memory port of the MA stage: request fields out, ack/read data back.
interface ma_stage_if;
  logic        dmem_req;
  logic        dmem_we;
  logic [29:0] dmem_adr;
  logic [3:0]  dmem_be;
  logic [31:0] dmem_wdata;
  logic        dmem_ack;
  logic [31:0] dmem_rdata;

  modport master (
    output dmem_req, dmem_we, dmem_adr, dmem_be, dmem_wdata,
    input  dmem_ack, dmem_rdata
  );

  modport slave (
    input  dmem_req, dmem_we, dmem_adr, dmem_be, dmem_wdata,
    output dmem_ack, dmem_rdata
  );
endinterface

// File: rtl/ma_stage.sv
// RV32I memory-access stage: issues loads/stores on the data-memory port,
// aligns load data, holds results across external stalls and drives the
// WB registers plus a second-level forwarding history.
module ma_stage (
  input  logic              clk,
  input  logic              rst,
  input  logic              cmd_ld_ma,
  input  logic              cmd_st_ma,
  input  logic [4:0]        rd_adr_ma,
  input  logic [31:0]       rd_data_ma,
  input  logic [31:0]       st_data_ma,
  input  logic [2:0]        ldst_code_ma,
  input  logic              wbk_rd_reg_ma,
  input  logic              stall_ext,
  input  logic              rst_pipe,
  ma_stage_if.master        dmem,
  output logic              ma_stall,
  output logic              misalign_exc,
  output logic [4:0]        rd_adr_wb,
  output logic [31:0]       wbk_data_wb,
  output logic              wbk_rd_reg_wb,
  output logic [4:0]        rd_adr_wb2,
  output logic [31:0]       wbk_data_wb2,
  output logic              wbk_rd_reg_wb2
);

  typedef enum logic [1:0] {IDLE, WAIT, HOLD} state_t;

  state_t      state;
  logic [31:0] hold_data;

  logic        size_h;
  logic        size_w;
  logic        ldst;
  logic        mis;
  logic        acc;
  logic [31:0] ld_word;
  logic [31:0] ld_shift;
  logic [31:0] ld_value;
  logic [31:0] wb_data_new;
  logic        wb_we_new;

  // Access classification; codes 011/110/111 fall into the word class.
  assign size_h = (ldst_code_ma[1:0] == 2'b01);
  assign size_w = ldst_code_ma[1];
  assign ldst   = cmd_ld_ma | cmd_st_ma;
  assign mis    = (size_h & rd_data_ma[0]) | (size_w & (rd_data_ma[1:0] != 2'b00));
  assign acc    = ldst & ~mis;

  assign misalign_exc = ldst & mis & ~stall_ext & ~rst_pipe & ~rst;

  // Request is live only while not yet accepted; HOLD must never reissue.
  assign dmem.dmem_req = acc & ((state == IDLE) | (state == WAIT)) & ~rst_pipe & ~rst;
  assign dmem.dmem_we  = cmd_st_ma;
  assign dmem.dmem_adr = rd_data_ma[31:2];
  assign ma_stall      = dmem.dmem_req & ~dmem.dmem_ack;

  // Store lane steering: byte enables and replicated write data.
  always_comb begin
    dmem.dmem_be    = 4'b1111;
    dmem.dmem_wdata = st_data_ma;
    case (ldst_code_ma[1:0])
      2'b00: begin
        dmem.dmem_be    = 4'b0001 << rd_data_ma[1:0];
        dmem.dmem_wdata = {4{st_data_ma[7:0]}};
      end
      2'b01: begin
        dmem.dmem_be    = 4'b0011 << {rd_data_ma[1], 1'b0};
        dmem.dmem_wdata = {2{st_data_ma[15:0]}};
      end
      default: begin
        dmem.dmem_be    = 4'b1111;
        dmem.dmem_wdata = st_data_ma;
      end
    endcase
  end

  // Load alignment and sign/zero extension.
  assign ld_word  = (state == HOLD) ? hold_data : dmem.dmem_rdata;
  assign ld_shift = ld_word >> {rd_data_ma[1:0], 3'b000};

  always_comb begin
    ld_value = ld_word;
    case (ldst_code_ma[1:0])
      2'b00:   ld_value = ldst_code_ma[2] ? {24'h0, ld_shift[7:0]}
                                          : {{24{ld_shift[7]}}, ld_shift[7:0]};
      2'b01:   ld_value = ldst_code_ma[2] ? {16'h0, ld_shift[15:0]}
                                          : {{16{ld_shift[15]}}, ld_shift[15:0]};
      default: ld_value = ld_word;
    endcase
  end

  assign wb_data_new = (cmd_ld_ma & ~mis) ? ld_value : rd_data_ma;
  assign wb_we_new   = wbk_rd_reg_ma & ~cmd_st_ma & ~(ldst & mis);

  // Access FSM; the hold register keeps read data acked under an external stall.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state     <= IDLE;
      hold_data <= 32'h0;
    end else if (rst_pipe) begin
      state     <= IDLE;
      hold_data <= 32'h0;
    end else begin
      case (state)
        IDLE: begin
          if (acc) begin
            if (!dmem.dmem_ack) begin
              state <= WAIT;
            end else if (stall_ext) begin
              state     <= HOLD;
              hold_data <= dmem.dmem_rdata;
            end
          end
        end
        WAIT: begin
          if (!acc) begin
            state <= IDLE;
          end else if (dmem.dmem_ack) begin
            if (stall_ext) begin
              state     <= HOLD;
              hold_data <= dmem.dmem_rdata;
            end else begin
              state <= IDLE;
            end
          end
        end
        HOLD: begin
          if (!stall_ext) state <= IDLE;
        end
        default: state <= IDLE;
      endcase
    end
  end

  // WB and forwarding history; advance only when the whole pipe advances.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      rd_adr_wb      <= 5'd0;
      wbk_data_wb    <= 32'h0;
      wbk_rd_reg_wb  <= 1'b0;
      rd_adr_wb2     <= 5'd0;
      wbk_data_wb2   <= 32'h0;
      wbk_rd_reg_wb2 <= 1'b0;
    end else if (rst_pipe) begin
      rd_adr_wb      <= 5'd0;
      wbk_data_wb    <= 32'h0;
      wbk_rd_reg_wb  <= 1'b0;
      rd_adr_wb2     <= 5'd0;
      wbk_data_wb2   <= 32'h0;
      wbk_rd_reg_wb2 <= 1'b0;
    end else if (!stall_ext && !ma_stall) begin
      rd_adr_wb2     <= rd_adr_wb;
      wbk_data_wb2   <= wbk_data_wb;
      wbk_rd_reg_wb2 <= wbk_rd_reg_wb;
      rd_adr_wb      <= rd_adr_ma;
      wbk_data_wb    <= wb_data_new;
      wbk_rd_reg_wb  <= wb_we_new;
    end
  end

endmodule

// File: tb/tb_ma_stage.sv
// Self-checking bench for ma_stage: vector table with a memory responder,
// scoreboard of expected WB results, and hand sequences for stall/flush/reset.
module tb_ma_stage;

  logic        clk;
  logic        rst;
  logic        cmd_ld_ma;
  logic        cmd_st_ma;
  logic [4:0]  rd_adr_ma;
  logic [31:0] rd_data_ma;
  logic [31:0] st_data_ma;
  logic [2:0]  ldst_code_ma;
  logic        wbk_rd_reg_ma;
  logic        stall_ext;
  logic        rst_pipe;
  logic        ma_stall;
  logic        misalign_exc;
  logic [4:0]  rd_adr_wb;
  logic [31:0] wbk_data_wb;
  logic        wbk_rd_reg_wb;
  logic [4:0]  rd_adr_wb2;
  logic [31:0] wbk_data_wb2;
  logic        wbk_rd_reg_wb2;

  ma_stage_if dmem_bus ();

  ma_stage dut (
    .clk            (clk),
    .rst            (rst),
    .cmd_ld_ma      (cmd_ld_ma),
    .cmd_st_ma      (cmd_st_ma),
    .rd_adr_ma      (rd_adr_ma),
    .rd_data_ma     (rd_data_ma),
    .st_data_ma     (st_data_ma),
    .ldst_code_ma   (ldst_code_ma),
    .wbk_rd_reg_ma  (wbk_rd_reg_ma),
    .stall_ext      (stall_ext),
    .rst_pipe       (rst_pipe),
    .dmem           (dmem_bus),
    .ma_stall       (ma_stall),
    .misalign_exc   (misalign_exc),
    .rd_adr_wb      (rd_adr_wb),
    .wbk_data_wb    (wbk_data_wb),
    .wbk_rd_reg_wb  (wbk_rd_reg_wb),
    .rd_adr_wb2     (rd_adr_wb2),
    .wbk_data_wb2   (wbk_data_wb2),
    .wbk_rd_reg_wb2 (wbk_rd_reg_wb2)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  typedef struct {
    logic        ld;
    logic        st;
    logic [4:0]  rd;
    logic [31:0] adr;
    logic [31:0] sdata;
    logic [2:0]  code;
    logic        wbk;
    logic [31:0] rdata;
    int          lat;
    logic        exp_req;
    logic        exp_mis;
    logic        chk_st;
    logic [3:0]  exp_be;
    logic [31:0] exp_wdata;
    logic [31:0] exp_wb;
    logic        exp_we;
    logic        chk_data;
  } vec_t;

  typedef struct {
    logic [4:0]  rd;
    logic [31:0] data;
    logic        we;
    logic        chk_data;
  } wb_t;

  int   checks = 0;
  int   errors = 0;
  wb_t  sb[$];
  wb_t  prev;
  vec_t vecs[$];

  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s actual=%h expected=%h", name, act, exp);
    end
  endtask

  task automatic drive(input logic ld, input logic st, input logic [4:0] rd,
                       input logic [31:0] adr, input logic [31:0] sdata,
                       input logic [2:0] code, input logic wbk);
    cmd_ld_ma     = ld;
    cmd_st_ma     = st;
    rd_adr_ma     = rd;
    rd_data_ma    = adr;
    st_data_ma    = sdata;
    ldst_code_ma  = code;
    wbk_rd_reg_ma = wbk;
  endtask

  // Pop the oldest expected WB entry and compare both WB levels.
  task automatic check_wb(input string tag);
    wb_t e;
    if (sb.size() == 0) begin
      checks++;
      errors++;
      $display("FAIL %s_sb_empty actual=0 expected=1", tag);
      return;
    end
    e = sb.pop_front();
    chk({tag, "_rd"}, 32'(rd_adr_wb), 32'(e.rd));
    chk({tag, "_we"}, 32'(wbk_rd_reg_wb), 32'(e.we));
    if (e.chk_data) chk({tag, "_data"}, wbk_data_wb, e.data);
    chk({tag, "_rd2"}, 32'(rd_adr_wb2), 32'(prev.rd));
    chk({tag, "_we2"}, 32'(wbk_rd_reg_wb2), 32'(prev.we));
    if (prev.chk_data) chk({tag, "_data2"}, wbk_data_wb2, prev.data);
    prev = e;
  endtask

  // Apply one vector from a falling edge; memory acks after v.lat cycles.
  task automatic apply(input int idx, input vec_t v);
    int          c;
    int          stalls;
    logic        stable;
    logic        done;
    logic [29:0] a0;
    logic [3:0]  b0;
    logic [31:0] w0;
    logic        we0;
    string       tag;
    tag = $sformatf("v%0d", idx);
    drive(v.ld, v.st, v.rd, v.adr, v.sdata, v.code, v.wbk);
    stall_ext = 1'b0;
    sb.push_back('{v.rd, v.exp_wb, v.exp_we, v.chk_data});
    c = 0; stalls = 0; stable = 1'b1; done = 1'b0;
    a0 = '0; b0 = '0; w0 = '0; we0 = 1'b0;
    while (!done && c < 20) begin
      dmem_bus.dmem_ack   = (v.ld | v.st) && (c >= v.lat);
      dmem_bus.dmem_rdata = (c >= v.lat) ? v.rdata : $urandom();
      #1;
      if (c == 0) begin
        chk({tag, "_req"}, 32'(dmem_bus.dmem_req), 32'(v.exp_req));
        chk({tag, "_mis"}, 32'(misalign_exc), 32'(v.exp_mis));
        if (v.exp_req) chk({tag, "_adr"}, 32'(dmem_bus.dmem_adr), {2'b00, v.adr[31:2]});
        if (v.chk_st) begin
          chk({tag, "_be"}, 32'(dmem_bus.dmem_be), 32'(v.exp_be));
          chk({tag, "_wdata"}, dmem_bus.dmem_wdata, v.exp_wdata);
          chk({tag, "_we_mem"}, 32'(dmem_bus.dmem_we), 32'd1);
        end
        a0 = dmem_bus.dmem_adr; b0 = dmem_bus.dmem_be;
        w0 = dmem_bus.dmem_wdata; we0 = dmem_bus.dmem_we;
      end else if (dmem_bus.dmem_req !== 1'b1 || dmem_bus.dmem_adr !== a0 ||
                   dmem_bus.dmem_be !== b0 || dmem_bus.dmem_wdata !== w0 ||
                   dmem_bus.dmem_we !== we0) begin
        stable = 1'b0;
      end
      if (ma_stall) stalls++;
      done = !(v.ld | v.st) || dmem_bus.dmem_ack;
      @(negedge clk);
      c++;
    end
    dmem_bus.dmem_ack = 1'b0;
    if (!done) begin
      checks++;
      errors++;
      $display("FAIL %s_timeout actual=%0d expected<20", tag, c);
    end
    chk({tag, "_stall_cycles"}, 32'(stalls), v.exp_req ? 32'(v.lat) : 32'd0);
    if (v.exp_req && v.lat > 0) chk({tag, "_stable"}, 32'(stable), 32'd1);
    check_wb(tag);
  endtask

  int reqs;

  initial begin
    rst = 1'b0; rst_pipe = 1'b0; stall_ext = 1'b0;
    drive(1'b0, 1'b0, 5'd0, 32'h0, 32'h0, 3'b000, 1'b0);
    dmem_bus.dmem_ack = 1'b0; dmem_bus.dmem_rdata = 32'h0;
    prev = '{5'd0, 32'h0, 1'b0, 1'b1};

    // Reset state
    #1 rst = 1'b1;
    #1;
    chk("rst_req", 32'(dmem_bus.dmem_req), 32'd0);
    chk("rst_stall", 32'(ma_stall), 32'd0);
    chk("rst_wb_data", wbk_data_wb, 32'h0);
    chk("rst_wb_we", 32'(wbk_rd_reg_wb), 32'd0);
    chk("rst_wb2_data", wbk_data_wb2, 32'h0);
    @(negedge clk);
    @(negedge clk);
    rst = 1'b0;

    // ld st rd adr sdata code wbk rdata lat | req mis chk_st be wdata | wb we chk_data
    vecs.push_back('{1,0,5'd1, 32'h100,32'h0,     3'b010,1,32'hDEADBEEF,0, 1,0,0,4'h0,32'h0,       32'hDEADBEEF,1,1});
    vecs.push_back('{1,0,5'd2, 32'h103,32'h0,     3'b000,1,32'h80112233,1, 1,0,0,4'h0,32'h0,       32'hFFFFFF80,1,1});
    vecs.push_back('{1,0,5'd3, 32'h103,32'h0,     3'b100,1,32'h80112233,0, 1,0,0,4'h0,32'h0,       32'h00000080,1,1});
    vecs.push_back('{1,0,5'd4, 32'h102,32'h0,     3'b101,1,32'h80112233,2, 1,0,0,4'h0,32'h0,       32'h00008011,1,1});
    vecs.push_back('{1,0,5'd5, 32'h102,32'h0,     3'b001,1,32'h80112233,0, 1,0,0,4'h0,32'h0,       32'hFFFF8011,1,1});
    vecs.push_back('{1,0,5'd6, 32'h101,32'h0,     3'b000,1,32'h80112233,0, 1,0,0,4'h0,32'h0,       32'h00000022,1,1});
    vecs.push_back('{0,1,5'd8, 32'h102,32'h0000ABCD,3'b001,1,32'h0,     3, 1,0,1,4'hC,32'hABCDABCD,32'h0,0,0});
    vecs.push_back('{0,1,5'd9, 32'h101,32'h123456AB,3'b000,1,32'h0,     1, 1,0,1,4'h2,32'hABABABAB,32'h0,0,0});
    vecs.push_back('{0,1,5'd10,32'h104,32'hCAFEF00D,3'b010,1,32'h0,     0, 1,0,1,4'hF,32'hCAFEF00D,32'h0,0,0});
    vecs.push_back('{1,0,5'd11,32'h101,32'h0,     3'b010,1,32'h0,       0, 0,1,0,4'h0,32'h0,       32'h0,0,0});
    vecs.push_back('{1,0,5'd12,32'h103,32'h0,     3'b001,1,32'h0,       0, 0,1,0,4'h0,32'h0,       32'h0,0,0});
    vecs.push_back('{0,1,5'd13,32'h106,32'h1,     3'b010,1,32'h0,       0, 0,1,0,4'h0,32'h0,       32'h0,0,0});
    vecs.push_back('{0,0,5'd7, 32'h12345679,32'h0,3'b010,1,32'h0,       0, 0,0,0,4'h0,32'h0,       32'h12345679,1,1});
    vecs.push_back('{1,0,5'd14,32'h108,32'h0,     3'b011,1,32'h0BADF00D,1, 1,0,0,4'h0,32'h0,       32'h0BADF00D,1,1});
    vecs.push_back('{1,0,5'd15,32'h10A,32'h0,     3'b111,1,32'h0,       0, 0,1,0,4'h0,32'h0,       32'h0,0,0});
    vecs.push_back('{1,0,5'd16,32'h100,32'h0,     3'b001,1,32'h0000F00F,0, 1,0,0,4'h0,32'h0,       32'hFFFFF00F,1,1});
    vecs.push_back('{1,0,5'd17,32'h100,32'h0,     3'b110,1,32'h87654321,0, 1,0,0,4'h0,32'h0,       32'h87654321,1,1});

    @(negedge clk);
    foreach (vecs[i]) apply(i, vecs[i]);

    // Load acked under external stall: hold data, no second request
    drive(1'b1, 1'b0, 5'd20, 32'h200, 32'h0, 3'b010, 1'b1);
    stall_ext = 1'b1;
    dmem_bus.dmem_ack = 1'b1; dmem_bus.dmem_rdata = 32'h11223344;
    sb.push_back('{5'd20, 32'h11223344, 1'b1, 1'b1});
    reqs = 0;
    #1;
    chk("hold_ack_req", 32'(dmem_bus.dmem_req), 32'd1);
    chk("hold_ack_stall", 32'(ma_stall), 32'd0);
    if (dmem_bus.dmem_req) reqs++;
    @(negedge clk);
    dmem_bus.dmem_ack = 1'b0; dmem_bus.dmem_rdata = 32'hFFFFFFFF;
    #1;
    chk("hold_req", 32'(dmem_bus.dmem_req), 32'd0);
    chk("hold_stall", 32'(ma_stall), 32'd0);
    chk("hold_wb_frozen", 32'(rd_adr_wb), 32'(prev.rd));
    if (dmem_bus.dmem_req) reqs++;
    @(negedge clk);
    stall_ext = 1'b0;
    #1;
    chk("hold_release_req", 32'(dmem_bus.dmem_req), 32'd0);
    if (dmem_bus.dmem_req) reqs++;
    @(negedge clk);
    chk("hold_single_req", 32'(reqs), 32'd1);
    check_wb("hold");

    // Pipeline flush while waiting on memory
    drive(1'b1, 1'b0, 5'd21, 32'h300, 32'h0, 3'b010, 1'b1);
    #1;
    chk("flush_req0", 32'(dmem_bus.dmem_req), 32'd1);
    @(negedge clk);
    #1;
    chk("flush_wait_req", 32'(dmem_bus.dmem_req), 32'd1);
    chk("flush_wait_stall", 32'(ma_stall), 32'd1);
    rst_pipe = 1'b1;
    sb.push_back('{5'd0, 32'h0, 1'b0, 1'b1});
    #1;
    chk("flush_req_drop", 32'(dmem_bus.dmem_req), 32'd0);
    chk("flush_stall_drop", 32'(ma_stall), 32'd0);
    @(negedge clk);
    rst_pipe = 1'b0;
    prev = '{5'd0, 32'h0, 1'b0, 1'b1};
    check_wb("flush");
    drive(1'b0, 1'b0, 5'd0, 32'h0, 32'h0, 3'b000, 1'b0);
    #1;
    chk("flush_idle_req", 32'(dmem_bus.dmem_req), 32'd0);

    // Asynchronous reset in the middle of a wait
    @(negedge clk);
    drive(1'b0, 1'b0, 5'd22, 32'h55, 32'h0, 3'b000, 1'b1);
    sb.push_back('{5'd22, 32'h55, 1'b1, 1'b1});
    @(negedge clk);
    check_wb("pre_rst");
    drive(1'b1, 1'b0, 5'd23, 32'h400, 32'h0, 3'b010, 1'b1);
    @(negedge clk);
    #1;
    chk("arst_wait_stall", 32'(ma_stall), 32'd1);
    chk("arst_wb_held", wbk_data_wb, 32'h55);
    #2 rst = 1'b1;
    #1;
    chk("arst_req", 32'(dmem_bus.dmem_req), 32'd0);
    chk("arst_stall", 32'(ma_stall), 32'd0);
    chk("arst_wb_data", wbk_data_wb, 32'h0);
    chk("arst_wb_we", 32'(wbk_rd_reg_wb), 32'd0);
    chk("arst_wb_rd", 32'(rd_adr_wb), 32'd0);
    chk("arst_wb2_data", wbk_data_wb2, 32'h0);
    @(negedge clk);
    rst = 1'b0;
    prev = '{5'd0, 32'h0, 1'b0, 1'b1};
    apply(99, vecs[0]);

    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule
